// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data RAM with GPIO and optional (DMEM_TIMER_EN) prescaled 64-bit timer MMIO
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int GPIO_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRW,
    input  logic [31:0]       Addr,
    input  logic [31:0]       DataW,
    output logic [31:0]       DataRM,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);
    localparam int AW = $clog2(DEPTH_WORDS);
    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;
    logic [5:0]    off;
    logic          wr_mmio;
    logic [31:0]   mmio_rd;
    logic          unused_addr;
    assign ram_idx     = Addr[AW+1:2];
    assign off         = Addr[7:2];
    assign wr_mmio     = MemRW & Addr[31];
    assign unused_addr = &{1'b0, Addr};
    assign DataRM      = Addr[31] ? mmio_rd : mem[ram_idx];
    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clk)
        if (MemRW && !Addr[31]) mem[ram_idx] <= DataW;
    // GPIO output register
    always_ff @(posedge clk or posedge reset)
        if (reset) gpio_out <= '0;
        else if (wr_mmio && off == 6'h00) gpio_out <= DataW[GPIO_W-1:0];
`ifdef DMEM_TIMER_EN
    logic [15:0] pcnt, prescale;
    logic [63:0] mtime, mtime_inc;
    logic [31:0] mtimecmp;
    logic        pending, irq_en, tick, wr_lo, wr_hi, wr_cmp, wr_st, wr_ps;
    logic        pend_set, pending_next, irq_en_next;
    assign tick         = pcnt == prescale;
    assign mtime_inc    = mtime + 64'd1;
    assign wr_lo        = wr_mmio && off == 6'h01;
    assign wr_hi        = wr_mmio && off == 6'h02;
    assign wr_cmp       = wr_mmio && off == 6'h03;
    assign wr_st        = wr_mmio && off == 6'h04;
    assign wr_ps        = wr_mmio && off == 6'h05;
    assign pend_set     = tick && !wr_lo && !wr_hi && mtime_inc[31:0] == mtimecmp;
    assign pending_next = pend_set | (pending & ~(wr_st & DataW[0]));
    assign irq_en_next  = wr_st ? DataW[1] : irq_en;
    // Prescaler, MTIME (software write beats the tick), compare and interrupt state
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pcnt      <= '0;
            prescale  <= '0;
            mtime     <= '0;
            mtimecmp  <= 32'hFFFF_FFFF;
            pending   <= 1'b0;
            irq_en    <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            pcnt      <= (wr_ps || tick) ? 16'd0 : pcnt + 16'd1;
            prescale  <= wr_ps ? DataW[15:0] : prescale;
            mtime     <= wr_lo ? {mtime[63:32], DataW} : wr_hi ? {DataW, mtime[31:0]} : tick ? mtime_inc : mtime;
            mtimecmp  <= wr_cmp ? DataW : mtimecmp;
            pending   <= pending_next;
            irq_en    <= irq_en_next;
            timer_irq <= pending_next & irq_en_next;
        end
    assign mmio_rd = off == 6'h00 ? 32'(gpio_out) :
                     off == 6'h01 ? mtime[31:0] :
                     off == 6'h02 ? mtime[63:32] :
                     off == 6'h03 ? mtimecmp :
                     off == 6'h04 ? {30'd0, irq_en, pending} :
                     off == 6'h05 ? {16'd0, prescale} : 32'd0;
`else
    assign timer_irq = 1'b0;
    assign mmio_rd   = off == 6'h00 ? 32'(gpio_out) : 32'd0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (timer checks follow DMEM_TIMER_EN)
module tb_dmem_responder;
    localparam logic [31:0] MM = 32'h8000_0000;
    logic        clk = 1'b0;
    logic        reset, MemRW, chk;
    logic [31:0] Addr, DataW, DataRM;
    logic [7:0]  gpio_out;
    logic        timer_irq;
    int          checks = 0;
    int          errors = 0;
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } item_t;
    item_t q[$];

    dmem_responder #(.DEPTH_WORDS(256), .GPIO_W(8)) dut (
        .clk(clk), .reset(reset), .MemRW(MemRW), .Addr(Addr), .DataW(DataW),
        .DataRM(DataRM), .gpio_out(gpio_out), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    // Monitor: kind 0 = DataRM, 1 = gpio_out, 2 = timer_irq
    always @(negedge clk) begin : mon
        item_t       it;
        logic [31:0] act;
        if (chk) begin
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: got sample request, required queued item");
            end else begin
                it  = q.pop_front();
                act = it.kind == 0 ? DataRM : it.kind == 1 ? 32'(gpio_out) : {31'd0, timer_irq};
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemRW = 1'b1; Addr = a; DataW = d;
        cyc(1);
        MemRW = 1'b0;
    endtask

    task automatic op(input string name, input int kind, input logic [31:0] a,
                      input logic rw, input logic [31:0] d, input logic [31:0] exp);
        item_t it;
        it.name = name; it.kind = kind; it.exp = exp;
        MemRW = rw; Addr = a; DataW = d;
        q.push_back(it);
        chk = 1'b1;
        @(negedge clk);
        #1 chk = 1'b0;
        @(posedge clk);
        #1 MemRW = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        op(name, 0, a, 1'b0, 32'd0, exp);
    endtask

    initial begin
        reset = 1'b1; MemRW = 1'b0; Addr = '0; DataW = '0; chk = 1'b0;
        cyc(2);
        reset = 1'b0;
        op("rst_gpio", 1, 32'd0, 1'b0, 32'd0, 32'h0);
        op("rst_irq", 2, 32'd0, 1'b0, 32'd0, 32'h0);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);
        rd("mmio_hole", MM + 32'h40, 32'h0);
        wr(32'h0000_0020, 32'h1111_1111);
        op("rdw_old", 0, 32'h0000_0020, 1'b1, 32'h2222_2222, 32'h1111_1111);
        rd("rdw_new", 32'h0000_0020, 32'h2222_2222);
        wr(MM, 32'h0000_01A5);
        op("gpio_out", 1, 32'd0, 1'b0, 32'd0, 32'hA5);
        rd("gpio_rd", MM, 32'h0000_00A5);
        rd("gpio_alias", MM | 32'h7FFF_FF00, 32'h0000_00A5);
`ifdef DMEM_TIMER_EN
        rd("rst_status", MM + 32'h10, 32'h0);
        rd("rst_cmp", MM + 32'h0C, 32'hFFFF_FFFF);
        rd("rst_prescale", MM + 32'h14, 32'h0);
        wr(MM + 32'h14, 32'h0001_2345);
        rd("prescale_w16", MM + 32'h14, 32'h0000_2345);
        wr(MM + 32'h08, 32'h0);
        wr(MM + 32'h14, 32'd3);
        wr(MM + 32'h04, 32'd0);
        cyc(20);
        rd("mtime_presc", MM + 32'h04, 32'd5);
        wr(MM + 32'h14, 32'd3);
        wr(MM + 32'h08, 32'h0);
        wr(MM + 32'h04, 32'hFFFF_FFFF);
        rd("wrap_before", MM + 32'h04, 32'hFFFF_FFFF);
        cyc(1);
        rd("wrap_lo", MM + 32'h04, 32'h0);
        rd("wrap_hi", MM + 32'h08, 32'h1);
        wr(MM + 32'h10, 32'h1);
        wr(MM + 32'h14, 32'd0);
        wr(MM + 32'h04, 32'd100);
        wr(MM + 32'h0C, 32'd10);
        wr(MM + 32'h08, 32'h0);
        wr(MM + 32'h10, 32'h2);
        wr(MM + 32'h04, 32'd0);
        cyc(8);
        op("irq_before", 2, 32'd0, 1'b0, 32'd0, 32'h0);
        rd("status_before", MM + 32'h10, 32'h2);
        op("irq_match", 2, 32'd0, 1'b0, 32'd0, 32'h1);
        rd("status_match", MM + 32'h10, 32'h3);
        wr(MM + 32'h10, 32'h3);
        op("irq_cleared", 2, 32'd0, 1'b0, 32'd0, 32'h0);
        rd("status_cleared", MM + 32'h10, 32'h2);
        wr(MM + 32'h04, 32'd0);
        cyc(9);
        wr(MM + 32'h10, 32'h3);
        rd("set_beats_clr", MM + 32'h10, 32'h3);
        op("irq_set_wins", 2, 32'd0, 1'b0, 32'd0, 32'h1);
`else
        wr(MM + 32'h0C, 32'h5);
        rd("off_cmp", MM + 32'h0C, 32'h0);
        wr(MM + 32'h04, 32'h5);
        rd("off_mtime", MM + 32'h04, 32'h0);
        wr(MM + 32'h14, 32'h0);
        wr(MM + 32'h10, 32'h3);
        rd("off_status", MM + 32'h10, 32'h0);
        for (int i = 0; i < 1000; i++) op("off_irq", 2, 32'd0, 1'b0, 32'd0, 32'h0);
`endif
        wr(MM, 32'h0000_005A);
        op("gpio_pre_rst", 1, 32'd0, 1'b0, 32'd0, 32'h5A);
        reset = 1'b1;
        op("gpio_async_rst", 1, 32'd0, 1'b0, 32'd0, 32'h0);
        op("irq_async_rst", 2, 32'd0, 1'b0, 32'd0, 32'h0);
        reset = 1'b0;
        rd("ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
`ifdef DMEM_TIMER_EN
        rd("rst2_status", MM + 32'h10, 32'h0);
        rd("rst2_cmp", MM + 32'h0C, 32'hFFFF_FFFF);
`endif
        cyc(2);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d unchecked items, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
